// File: rtl/snn_conv_pkg.sv
// Shared types and helpers for the convolution input sequencer.
//   fsm_e          : sequencer state (IDLE / FEED / DRAIN)
//   DATA_WIDTH_DEF : default feature-map word width
//   out_w()        : number of window positions along one axis
//   cols()         : number of im2col columns (PE array inputs)
package snn_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } fsm_e;

  localparam int DATA_WIDTH_DEF = 32;

  function automatic int out_w(input int frame_width, input int kernel_size, input int stride);
    return (frame_width - kernel_size) / stride + 1;
  endfunction

  function automatic int cols(input int in_channels, input int kernel_size);
    return in_channels * kernel_size * kernel_size;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length register delay line used to skew one im2col column.
//   clk, rst : clock, synchronous active-high clear of all stages
//   d        : input word
//   q        : d delayed by DEPTH cycles (DEPTH=0 is a plain wire)
module skew_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Clock and reset have nothing to drive in the pass-through case.
      logic pass_unused;
      assign pass_unused = clk ^ rst;
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end
      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/conv_skew_feeder.sv
// Conv-core input sequencer. Buffers IN_CHANNELS feature maps, slides a
// KERNEL_SIZE window with STRIDE in raster order and emits skewed im2col
// columns to the PE array, repeating for TIME_STEPS x PHASES passes.
//   clk, rst            : clock, synchronous active-high reset
//   pre_syn_RAM_loaded  : start a run (sampled only in IDLE)
//   wr_en/addr/data     : feature-map buffer write port (IDLE only)
//   wr_err              : one-cycle flag, write attempted outside IDLE
//   col_in / col_valid  : skewed column data and valid, column c = ic*K*K+ky*K+kx
//   transit             : pulse, time step finished (clear PE accumulators)
//   new_oc              : pulse, output-channel phase finished
//   oc_phase, time_step : current phase / time step
//   en_thresh           : per-row thresholding enable
//   thr_pix             : output pixel index of row 0
//   new_spk_train_ready : pulse, spike frame complete
//   post_syn_RAM_loaded : pulse, whole run complete
//
// Handshake: pre_syn_RAM_loaded acts as a level-sampled request that is
// accepted only while IDLE; every status output (transit, new_oc,
// new_spk_train_ready, post_syn_RAM_loaded) is a single-cycle pulse issued in
// the last DRAIN cycle of a pass and needs no acknowledge.
module conv_skew_feeder import snn_conv_pkg::*; #(
  parameter int TIME_STEPS        = 3,
  parameter int IN_CHANNELS       = 3,
  parameter int OUT_CHANNELS      = 16,
  parameter int FRAME_WIDTH       = 6,
  parameter int KERNEL_SIZE       = 3,
  parameter int STRIDE            = 1,
  parameter int PE_ARRAY_ROW_SIZE = 2,
  parameter int ARRAY_LAT         = 1,
  parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
  localparam int COLS      = cols(IN_CHANNELS, KERNEL_SIZE),
  localparam int OUT_W     = out_w(FRAME_WIDTH, KERNEL_SIZE, STRIDE),
  localparam int PHASES    = OUT_CHANNELS / PE_ARRAY_ROW_SIZE,
  localparam int WINDOWS   = OUT_W * OUT_W,
  localparam int WORDS     = IN_CHANNELS * FRAME_WIDTH * FRAME_WIDTH,
  localparam int ADDR_W    = $clog2(WORDS),
  localparam int PH_W      = $clog2(PHASES) + 1,
  localparam int TS_W      = $clog2(TIME_STEPS) + 1,
  localparam int PIX_W     = $clog2(WINDOWS) + 1,
  localparam int DRAIN_LEN = COLS + ARRAY_LAT + PE_ARRAY_ROW_SIZE,
  localparam int DR_W      = $clog2(DRAIN_LEN) + 1,
  localparam int XY_W      = $clog2(OUT_W) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pre_syn_RAM_loaded,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_err,
  output logic [COLS*DATA_WIDTH-1:0]   col_in,
  output logic [COLS-1:0]              col_valid,
  output logic                         transit,
  output logic                         new_oc,
  output logic [PH_W-1:0]              oc_phase,
  output logic [TS_W-1:0]              time_step,
  output logic [PE_ARRAY_ROW_SIZE-1:0] en_thresh,
  output logic [PIX_W-1:0]             thr_pix,
  output logic                         new_spk_train_ready,
  output logic                         post_syn_RAM_loaded
);

  fsm_e state, state_next;

  logic [XY_W-1:0] ox, oy;
  logic [DR_W-1:0] drain_cnt;
  logic            last_window, drain_last, step_last, phase_last;
  logic            feed_active;

  // Feature-map buffer: no reset, contents survive reset and aborted runs.
  logic [DATA_WIDTH-1:0] fmap_mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE)) fmap_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= wr_en && (state != IDLE);
  end

  assign last_window = (ox == XY_W'(OUT_W - 1)) && (oy == XY_W'(OUT_W - 1));
  assign drain_last  = (drain_cnt == DR_W'(DRAIN_LEN - 1));
  assign step_last   = (time_step == TS_W'(TIME_STEPS - 1));
  assign phase_last  = (oc_phase == PH_W'(PHASES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pre_syn_RAM_loaded) state_next = FEED;
      FEED:    if (last_window) state_next = DRAIN;
      DRAIN:   if (drain_last) state_next = (step_last && phase_last) ? IDLE : FEED;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; pulses fire in the last DRAIN cycle.
  always_comb begin
    feed_active         = (state == FEED);
    transit             = 1'b0;
    new_spk_train_ready = 1'b0;
    new_oc              = 1'b0;
    post_syn_RAM_loaded = 1'b0;
    if ((state == DRAIN) && drain_last) begin
      transit             = 1'b1;
      new_spk_train_ready = 1'b1;
      new_oc              = step_last;
      post_syn_RAM_loaded = step_last && phase_last;
    end
  end

  // Window position, drain timer, time step and phase counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ox        <= '0;
      oy        <= '0;
      drain_cnt <= '0;
      time_step <= '0;
      oc_phase  <= '0;
    end else begin
      if (state == FEED) begin
        if (ox == XY_W'(OUT_W - 1)) begin
          ox <= '0;
          oy <= last_window ? '0 : oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end
      drain_cnt <= ((state == DRAIN) && !drain_last) ? drain_cnt + 1'b1 : '0;
      if ((state == DRAIN) && drain_last) begin
        if (step_last) begin
          time_step <= '0;
          oc_phase  <= phase_last ? '0 : oc_phase + 1'b1;
        end else begin
          time_step <= time_step + 1'b1;
        end
      end
    end
  end

  // Window origin; each column adds its own constant offset, so a window
  // (whose origin keeps ox*STRIDE+K-1 inside the row) never wraps a row.
  logic [ADDR_W-1:0] win_base;
  assign win_base = ADDR_W'(int'(oy) * (STRIDE * FRAME_WIDTH) + int'(ox) * STRIDE);

  // Stage-0 valid is shared by all columns; outside FEED it injects zeros.
  logic s0_valid;
  always_ff @(posedge clk) begin
    if (rst) s0_valid <= 1'b0;
    else     s0_valid <= feed_active;
  end

  generate
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int IC     = c / (KERNEL_SIZE * KERNEL_SIZE);
      localparam int KY     = (c / KERNEL_SIZE) % KERNEL_SIZE;
      localparam int KX     = c % KERNEL_SIZE;
      localparam int OFFSET = IC * FRAME_WIDTH * FRAME_WIDTH + KY * FRAME_WIDTH + KX;

      logic [ADDR_W-1:0]     rd_addr;
      logic [DATA_WIDTH-1:0] s0_data;
      logic [DATA_WIDTH:0]   line_q;

      assign rd_addr = win_base + ADDR_W'(OFFSET);

      always_ff @(posedge clk) begin
        if (rst) s0_data <= '0;
        else     s0_data <= feed_active ? fmap_mem[rd_addr] : '0;
      end

      // Column c lags column 0 by c cycles so the array sees a wavefront.
      skew_delay_line #(
        .WIDTH(DATA_WIDTH + 1),
        .DEPTH(c)
      ) u_line (
        .clk (clk),
        .rst (rst),
        .d   ({s0_valid, s0_data}),
        .q   (line_q)
      );

      assign col_valid[c]                        = line_q[DATA_WIDTH];
      assign col_in[c*DATA_WIDTH +: DATA_WIDTH]  = line_q[DATA_WIDTH-1:0];
    end
  endgenerate

  // Threshold enables: last column valid delayed ARRAY_LAT+r cycles for row r.
  // Assumes ARRAY_LAT >= 1, so the tap chain is at least two bits long.
  localparam int TAPS = ARRAY_LAT + PE_ARRAY_ROW_SIZE;
  logic [TAPS-1:0] vtap;
  logic [TAPS-2:0] vhist;

  assign vtap = {vhist, col_valid[COLS-1]};

  always_ff @(posedge clk) begin
    if (rst) vhist <= '0;
    else     vhist <= vtap[TAPS-2:0];
  end

  generate
    for (genvar r = 0; r < PE_ARRAY_ROW_SIZE; r++) begin : g_thr
      assign en_thresh[r] = vtap[ARRAY_LAT + r];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)               thr_pix <= '0;
    else if (transit)      thr_pix <= '0;
    else if (en_thresh[0]) thr_pix <= thr_pix + 1'b1;
  end

endmodule

// File: tb/tb_conv_skew_feeder.sv
`timescale 1ns/1ps
module tb_conv_skew_feeder;

  localparam int DW     = 32;
  localparam int NCOL   = 27;
  localparam int STEPS  = 24;            // 3 time steps x 8 phases
  localparam int WIN_A  = 16;            // 4x4 windows, 6x6 frame, stride 1
  localparam int WIN_B  = 9;             // 3x3 windows, 7x7 frame, stride 2
  localparam int LOFF_A = 2*36 + 2*6 + 2; // last column offset, frame 6
  localparam int LOFF_B = 2*49 + 2*7 + 2; // last column offset, frame 7

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: defaults ----------------
  logic              pre_a = 0, wr_en_a = 0;
  logic [6:0]        wr_addr_a = '0;
  logic [DW-1:0]     wr_data_a = '0;
  logic              wr_err_a, transit_a, new_oc_a, nstr_a, post_a;
  logic [NCOL*DW-1:0] col_in_a;
  logic [NCOL-1:0]   col_valid_a;
  logic [3:0]        oc_phase_a;
  logic [2:0]        time_step_a;
  logic [1:0]        en_thresh_a;
  logic [4:0]        thr_pix_a;

  conv_skew_feeder dut_a (
    .clk(clk), .rst(rst), .pre_syn_RAM_loaded(pre_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_err(wr_err_a),
    .col_in(col_in_a), .col_valid(col_valid_a), .transit(transit_a), .new_oc(new_oc_a),
    .oc_phase(oc_phase_a), .time_step(time_step_a), .en_thresh(en_thresh_a),
    .thr_pix(thr_pix_a), .new_spk_train_ready(nstr_a), .post_syn_RAM_loaded(post_a)
  );

  // ---------------- DUT B: frame 7, stride 2 ----------------
  logic              pre_b = 0, wr_en_b = 0;
  logic [7:0]        wr_addr_b = '0;
  logic [DW-1:0]     wr_data_b = '0;
  logic              wr_err_b, transit_b, new_oc_b, nstr_b, post_b;
  logic [NCOL*DW-1:0] col_in_b;
  logic [NCOL-1:0]   col_valid_b;
  logic [3:0]        oc_phase_b;
  logic [2:0]        time_step_b;
  logic [1:0]        en_thresh_b;
  logic [4:0]        thr_pix_b;

  conv_skew_feeder #(.FRAME_WIDTH(7), .STRIDE(2)) dut_b (
    .clk(clk), .rst(rst), .pre_syn_RAM_loaded(pre_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_err(wr_err_b),
    .col_in(col_in_b), .col_valid(col_valid_b), .transit(transit_b), .new_oc(new_oc_b),
    .oc_phase(oc_phase_b), .time_step(time_step_b), .en_thresh(en_thresh_b),
    .thr_pix(thr_pix_b), .new_spk_train_ready(nstr_b), .post_syn_RAM_loaded(post_b)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [DW-1:0] exp0_a[$];
  logic [DW-1:0] expl_a[$];
  logic [DW-1:0] exp0_b[$];
  logic sb_a = 0, sb_b = 0;
  int n_tr_a, n_oc_a, n_sp_a, n_post_a, n_en0_a, first0_a, firstl_a, start_a;
  int n_tr_b, n_post_b, en_step_b;
  int orig_b[9] = '{0, 2, 4, 14, 16, 18, 28, 30, 32};

  always @(negedge clk) begin
    if (sb_a) begin
      if (col_valid_a[0]) begin
        if (first0_a < 0) first0_a = cyc - start_a;
        check("col0_queue_a", exp0_a.size() > 0, 1);
        if (exp0_a.size() > 0) check("col0_data_a", col_in_a[DW-1:0], exp0_a.pop_front());
      end else begin
        check("col0_zero_a", col_in_a[DW-1:0], 0);
      end
      if (col_valid_a[NCOL-1]) begin
        if (firstl_a < 0) firstl_a = cyc - start_a;
        check("collast_queue_a", expl_a.size() > 0, 1);
        if (expl_a.size() > 0) check("collast_data_a", col_in_a[(NCOL-1)*DW +: DW], expl_a.pop_front());
      end
      if (en_thresh_a[0]) n_en0_a++;
      if (transit_a) begin
        check("time_step_a", time_step_a, n_tr_a % 3);
        check("thr_pix_a", thr_pix_a, WIN_A);
        n_tr_a++;
      end
      if (new_oc_a) begin
        check("oc_phase_a", oc_phase_a, n_oc_a);
        n_oc_a++;
      end
      if (nstr_a) n_sp_a++;
      if (post_a) n_post_a++;
    end
    if (sb_b) begin
      if (col_valid_b[0]) begin
        check("col0_queue_b", exp0_b.size() > 0, 1);
        if (exp0_b.size() > 0) check("col0_data_b", col_in_b[DW-1:0], exp0_b.pop_front());
      end
      if (en_thresh_b[0]) en_step_b++;
      if (transit_b) begin
        check("en0_per_step_b", en_step_b, WIN_B);
        check("thr_pix_b", thr_pix_b, WIN_B);
        en_step_b = 0;
        n_tr_b++;
      end
      if (post_b) n_post_b++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic clear_a_counts();
    n_tr_a = 0; n_oc_a = 0; n_sp_a = 0; n_post_a = 0; n_en0_a = 0;
    first0_a = -1; firstl_a = -1;
    exp0_a.delete(); expl_a.delete();
    for (int s = 0; s < STEPS; s++) begin
      for (int w = 0; w < WIN_A; w++) begin
        exp0_a.push_back(DW'((w / 4) * 6 + (w % 4)));
        expl_a.push_back(DW'((w / 4) * 6 + (w % 4) + LOFF_A));
      end
    end
  endtask

  task automatic check_a_run(input string tag);
    check({tag, "_transit"}, n_tr_a, STEPS);
    check({tag, "_spk_ready"}, n_sp_a, STEPS);
    check({tag, "_new_oc"}, n_oc_a, 8);
    check({tag, "_post"}, n_post_a, 1);
    check({tag, "_en0_total"}, n_en0_a, STEPS * WIN_A);
    check({tag, "_col0_latency"}, first0_a, 1);
    check({tag, "_collast_latency"}, firstl_a, 27);
    check({tag, "_q0_left"}, exp0_a.size(), 0);
    check({tag, "_ql_left"}, expl_a.size(), 0);
    check({tag, "_oc_phase_end"}, oc_phase_a, 0);
    check({tag, "_time_step_end"}, time_step_a, 0);
    check({tag, "_thr_pix_end"}, thr_pix_a, 0);
  endtask

  task automatic wait_post_a(input string tag, output int seen_cyc);
    int got = 0;
    seen_cyc = -1;
    for (int i = 0; i < 3000 && got == 0; i++) begin
      @(negedge clk);
      if (post_a) begin got = 1; seen_cyc = cyc; end
    end
    check(tag, got, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int post_cyc, rise_cyc, got, act;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col_valid_a", col_valid_a, 0);
    check("rst_col_in_a", |col_in_a, 0);
    check("rst_pulses_a", {transit_a, new_oc_a, nstr_a, post_a, wr_err_a}, 0);
    check("rst_counters_a", {oc_phase_a, time_step_a, thr_pix_a, en_thresh_a}, 0);
    check("rst_col_valid_b", col_valid_b, 0);
    rst = 1'b0;

    // load fmap A, word = address
    for (int a = 0; a < 108; a++) begin
      @(negedge clk);
      wr_en_a = 1'b1; wr_addr_a = 7'(a); wr_data_a = DW'(a);
    end
    @(negedge clk);
    wr_en_a = 1'b0;
    check("wr_err_idle_a", wr_err_a, 0);

    // full clean run A, with a rejected write during FEED
    clear_a_counts();
    sb_a = 1'b1;
    @(negedge clk); pre_a = 1'b1; start_a = cyc + 1;
    @(negedge clk); pre_a = 1'b0;
    repeat (3) @(negedge clk);
    wr_en_a = 1'b1; wr_addr_a = 7'd0; wr_data_a = 32'hDEAD;
    @(negedge clk); wr_en_a = 1'b0;
    check("wr_err_feed_a", wr_err_a, 1);
    @(negedge clk);
    check("wr_err_clear_a", wr_err_a, 0);
    wait_post_a("post_seen_run1_a", post_cyc);
    @(negedge clk);
    sb_a = 1'b0;
    check_a_run("run1_a");

    // abort a run with reset at FEED cycle 5
    @(negedge clk); pre_a = 1'b1;
    @(negedge clk); pre_a = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_col_valid_a", col_valid_a, 0);
    check("abort_col_in_a", |col_in_a, 0);
    check("abort_outputs_a", {transit_a, new_oc_a, nstr_a, post_a, en_thresh_a}, 0);
    check("abort_counters_a", {oc_phase_a, time_step_a, thr_pix_a}, 0);
    act = 0;
    repeat (60) begin
      @(negedge clk);
      if ((|col_valid_a) || transit_a || nstr_a || post_a || (|en_thresh_a)) act++;
    end
    check("abort_quiet_a", act, 0);

    // rerun with pre_syn_RAM_loaded held high; buffer must be unchanged
    clear_a_counts();
    sb_a = 1'b1;
    @(negedge clk); pre_a = 1'b1; start_a = cyc + 1;
    wait_post_a("post_seen_run2_a", post_cyc);
    @(negedge clk);
    sb_a = 1'b0;
    check_a_run("run2_a");
    got = 0; rise_cyc = -1;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (col_valid_a[0]) begin got = 1; rise_cyc = cyc; end
    end
    check("restart_delay_a", rise_cyc - post_cyc, 3);
    pre_a = 1'b0;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // DUT B: frame 7, stride 2
    for (int a = 0; a < 147; a++) begin
      @(negedge clk);
      wr_en_b = 1'b1; wr_addr_b = 8'(a); wr_data_b = DW'(a);
    end
    @(negedge clk);
    wr_en_b = 1'b0;
    check("wr_err_idle_b", wr_err_b, 0);
    n_tr_b = 0; n_post_b = 0; en_step_b = 0;
    for (int s = 0; s < STEPS; s++)
      for (int w = 0; w < WIN_B; w++) exp0_b.push_back(DW'(orig_b[w]));
    sb_b = 1'b1;
    @(negedge clk); pre_b = 1'b1;
    @(negedge clk); pre_b = 1'b0;
    got = 0;
    for (int i = 0; i < 3000 && got == 0; i++) begin
      @(negedge clk);
      if (post_b) got = 1;
    end
    check("post_seen_b", got, 1);
    @(negedge clk);
    sb_b = 1'b0;
    check("transit_b", n_tr_b, STEPS);
    check("post_b", n_post_b, 1);
    check("q0_left_b", exp0_b.size(), 0);
    check("collast_offset_idle_b", col_valid_b, 0);
    check("oc_phase_end_b", oc_phase_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
